data_mem_unit: RTL and testbench

Parametrised, byte-addressed data memory for the pipeline's MEM stage. It supports byte, half, word and doubleword accesses with optional sign extension, a valid/ready request handshake and a registered response. Accesses that cross an 8-byte row are split into two internal cycles, and out-of-range accesses are flagged. It replaces the fixed 64-bit combinational-read memory and sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_row_array.sv | 30 +++
 rtl/data_mem_unit.sv | 136 +++++++++++++
 tb/tb_data_mem_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic {IDLE, SPLIT} state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        sgn;
    logic [63:0] wdata;
  } op_t;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

  // Bytes above the access length are discarded, then sign- or zero-filled.
  function automatic logic [63:0] extend(input logic [63:0] d, input size_e sz, input logic sgn);
    logic [63:0] r;
    r = d;
    case (sz)
      SZ_B:    r = {{56{sgn & d[7]}},  d[7:0]};
      SZ_H:    r = {{48{sgn & d[15]}}, d[15:0]};
      SZ_W:    r = {{32{sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_row_array.sv
// Row storage: 8 byte lanes per row, byte-enabled write, async read of rows r and r+1.
module dmem_row_array #(
  parameter int ROWS = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(ROWS)-1:0]  wrow,
  input  logic [7:0]               wbe,
  input  logic [63:0]              wdata,
  input  logic [$clog2(ROWS)-1:0]  rrow,
  output logic [63:0]              rd_lo,
  output logic [63:0]              rd_hi
);
  localparam int ROW_W = $clog2(ROWS);

  logic [63:0] mem [ROWS];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wbe[b]) mem[wrow][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rd_lo = mem[rrow];
  assign rd_hi = mem[ROW_W'(rrow + 1'b1)];

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed data memory with valid/ready requests, registered response,
// two-cycle handling of row-crossing accesses and out-of-range flagging.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int ROWS  = DEPTH_BYTES / 8;
  localparam int ROW_W = $clog2(ROWS);

  state_e            state, state_nx;
  op_t               lat_op, cur_op;
  logic [ADDR_W-1:0] lat_addr, cur_addr;

  logic [2:0]        lane;
  logic [ROW_W-1:0]  row;
  logic [3:0]        nbytes;
  logic [ADDR_W:0]   last_byte;
  logic              err, crosses;
  logic [15:0]       be16;
  logic [127:0]      wd128, rd128;
  logic [63:0]       rd_lo, rd_hi;

  logic              acc, done, wr_en;
  logic [ROW_W-1:0]  wr_row;
  logic [7:0]        wr_be;
  logic [63:0]       wr_data;

  // In SPLIT the latched request drives the datapath; otherwise the live port does.
  always_comb begin
    cur_op   = '{we: req_we, size: size_e'(req_size), sgn: req_signed, wdata: req_wdata};
    cur_addr = req_addr;
    if (state == SPLIT) begin
      cur_op   = lat_op;
      cur_addr = lat_addr;
    end
  end

  assign lane      = cur_addr[2:0];
  assign row       = cur_addr[ROW_W+2:3];
  assign nbytes    = size_bytes(cur_op.size);
  // One extra bit so that a wrapping address can never alias into range.
  assign last_byte = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
  assign err       = last_byte >= (ADDR_W+1)'(DEPTH_BYTES);
  assign crosses   = ({1'b0, lane} + nbytes) > 4'd8;

  // Two-row view: low half targets row, high half targets row+1.
  assign be16  = ((16'd1 << nbytes) - 16'd1) << lane;
  assign wd128 = {64'd0, cur_op.wdata} << {lane, 3'b000};
  assign rd128 = {rd_hi, rd_lo} >> {lane, 3'b000};

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    acc       = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    wr_row    = row;
    wr_be     = be16[7:0];
    wr_data   = wd128[63:0];
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        acc       = req_valid & rst_n;
        if (acc) begin
          wr_en = cur_op.we & ~err;
          if (err || !crosses) done     = 1'b1;
          else                 state_nx = SPLIT;
        end
      end
      SPLIT: begin
        wr_row   = ROW_W'(row + 1'b1);
        wr_be    = be16[15:8];
        wr_data  = wd128[127:64];
        wr_en    = cur_op.we;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  dmem_row_array #(.ROWS(ROWS)) u_rows (
    .clk   (clk),
    .we    (wr_en),
    .wrow  (wr_row),
    .wbe   (wr_be),
    .wdata (wr_data),
    .rrow  (row),
    .rd_lo (rd_lo),
    .rd_hi (rd_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_op   <= '0;
      lat_addr <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        lat_op   <= cur_op;
        lat_addr <= cur_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_err   <= err;
        rsp_rdata <= (!cur_op.we && !err) ? extend(rd128[63:0], cur_op.size, cur_op.sgn) : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Vector table plus scoreboard bench for data_mem_unit, with reset corner sequences.
module tb_data_mem_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          due;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_rd = 64'd0;
  vec_t        tbl[$];

  data_mem_unit #(.DEPTH_BYTES(256), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        exp_t m;
        m = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_rsp id=%0d actual=none required=cycle %0d", m.id, m.due);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=rsp_valid=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("rdata[%0d]", e.id), rsp_rdata, e.rd);
          chk($sformatf("err[%0d]", e.id), 64'(rsp_err), 64'(e.err));
          chk($sformatf("latency[%0d]", e.id), 64'(cyc), 64'(e.due));
          last_rd = e.rd;
        end
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sgn,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rd, input logic er, input int lat);
    vec_t v;
    v.we = we; v.size = sz; v.sgn = sgn; v.addr = a; v.wdata = wd;
    v.exp_rd = rd; v.exp_err = er; v.lat = lat;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input vec_t v, input int id);
    int guard = 0;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    while (!req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout[%0d] actual=req_ready=0 required=1", id);
    end else begin
      sb.push_back('{rd: v.exp_rd, err: v.exp_err, due: cyc + v.lat, id: id});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 64'h40; req_wdata = 64'h55;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);

    tbl.push_back(mk(1, 2'd3, 0, 64'h10, 64'h8877665544332211, 64'h0, 0, 1));
    tbl.push_back(mk(0, 2'd1, 1, 64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 0, 1));
    tbl.push_back(mk(0, 2'd3, 0, 64'h10, 64'h0, 64'h8877665544332211, 0, 1));
    tbl.push_back(mk(1, 2'd2, 0, 64'h1E, 64'hDEADBEEF, 64'h0, 0, 2));
    tbl.push_back(mk(0, 2'd2, 0, 64'h1E, 64'h0, 64'h00000000DEADBEEF, 0, 2));
    tbl.push_back(mk(0, 2'd1, 1, 64'h1F, 64'h0, 64'hFFFFFFFFFFFFADBE, 0, 2));
    tbl.push_back(mk(1, 2'd0, 0, 64'h10, 64'hAAAAAAAAAAAAAA7F, 64'h0, 0, 1));
    tbl.push_back(mk(0, 2'd0, 1, 64'h10, 64'h0, 64'h000000000000007F, 0, 1));
    tbl.push_back(mk(0, 2'd3, 0, 64'h10, 64'h0, 64'h887766554433227F, 0, 1));
    tbl.push_back(mk(1, 2'd0, 0, 64'h10, 64'h80, 64'h0, 0, 1));
    tbl.push_back(mk(0, 2'd0, 1, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1));
    tbl.push_back(mk(0, 2'd0, 0, 64'h10, 64'h0, 64'h0000000000000080, 0, 1));
    tbl.push_back(mk(0, 2'd2, 1, 64'h12, 64'h0, 64'h0000000066554433, 0, 1));
    tbl.push_back(mk(0, 2'd2, 1, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 0, 1));
    tbl.push_back(mk(1, 2'd3, 0, 64'hF8, 64'hF7F6F5F4F3F2F1F0, 64'h0, 0, 1));
    tbl.push_back(mk(1, 2'd3, 0, 64'hF9, 64'h1122334455667788, 64'h0, 1, 1));
    tbl.push_back(mk(0, 2'd3, 0, 64'hF9, 64'h0, 64'h0, 1, 1));
    tbl.push_back(mk(0, 2'd3, 0, 64'hF8, 64'h0, 64'hF7F6F5F4F3F2F1F0, 0, 1));
    tbl.push_back(mk(0, 2'd0, 0, 64'hFF, 64'h0, 64'h00000000000000F7, 0, 1));
    tbl.push_back(mk(0, 2'd1, 0, 64'hFF, 64'h0, 64'h0, 1, 1));
    tbl.push_back(mk(0, 2'd1, 0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1, 1));
    tbl.push_back(mk(0, 2'd0, 0, 64'h100, 64'h0, 64'h0, 1, 1));
    tbl.push_back(mk(1, 2'd1, 0, 64'h0F, 64'hBBAA, 64'h0, 0, 2));
    tbl.push_back(mk(0, 2'd1, 0, 64'h0F, 64'h0, 64'h000000000000BBAA, 0, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i], i);
      if (tbl[i].lat == 2) begin
        chk($sformatf("split_ready_low[%0d]", i), 64'(req_ready), 64'd0);
        @(negedge clk);
        chk($sformatf("split_ready_back[%0d]", i), 64'(req_ready), 64'd1);
      end
    end
    drain();
    chk("rdata_hold_valid", 64'(rsp_valid), 64'd0);
    chk("rdata_hold", rsp_rdata, last_rd);

    // Reset in SPLIT of a row-crossing double store at 0x2C.
    send(mk(1, 2'd3, 0, 64'h28, 64'h0, 64'h0, 0, 1), 100);
    send(mk(1, 2'd3, 0, 64'h30, 64'h0, 64'h0, 0, 1), 101);
    drain();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 64'h2C; req_wdata = 64'hA1A2A3A4A5A6A7A8;
    @(negedge clk);
    chk("abort_in_split", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    req_size = 2'd0; req_addr = 64'h30; req_wdata = 64'hEE;
    @(negedge clk);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_rsp_after", 64'(rsp_valid), 64'd0);
    chk("abort_ready_after", 64'(req_ready), 64'd1);
    send(mk(0, 2'd3, 0, 64'h28, 64'h0, 64'hA5A6A7A800000000, 0, 1), 102);
    send(mk(0, 2'd3, 0, 64'h30, 64'h0, 64'h0, 0, 1), 103);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
